sd_cmd_seq: RTL and testbench

//  Sequences SD-card SPI-mode commands through the byte-wide SPI shift engine (sd_ctrl).

---
 rtl/sd_cmd_seq_pkg.sv | 41 ++++
 rtl/sd_cmd_seq_byte_hs.sv | 86 ++++++++
 rtl/sd_cmd_seq.sv | 199 +++++++++++++++++++
 tb/tb_sd_cmd_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_seq_pkg.sv
// Shared definitions for the SD SPI-mode command sequencer: state encodings,
// framing constants and the CRC7 byte-update helper (used when SD_CRC7_EN is defined).
package sd_cmd_seq_pkg;

    localparam logic [7:0] SD_DUMMY     = 8'hFF;
    localparam logic [1:0] SD_START     = 2'b01;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_PRE,
        ST_CMD,
        ST_POLL,
        ST_POST,
        ST_FIN
    } seq_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_GO,
        HS_WAIT_BUSY,
        HS_WAIT_IDLE
    } hs_state_t;

    // MSB-first CRC7 update (x^7+x^3+1) over one byte.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ SD_CRC7_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_cmd_seq_byte_hs.sv
// Per-byte handshake with the SPI shift engine: GO pulse, wait for busy, wait for idle,
// with a 2-flop idle synchroniser and a busy/idle watchdog that reports err.
module sd_cmd_seq_byte_hs
    import sd_cmd_seq_pkg::*;
#(
    parameter int GO_W     = 4,
    parameter int BUSY_TMO = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       done,
    output logic       err,
    output logic       byte_go,
    output logic [7:0] byte_tx,
    input  logic [7:0] byte_rx,
    input  logic       byte_idle
);

    localparam int CNT_W = $clog2(BUSY_TMO + GO_W + 1);
    localparam logic [CNT_W-1:0] GO_LAST  = CNT_W'(GO_W - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO - 1);

    hs_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             idle_meta_reg, idle_sync_reg;
    logic [7:0]       tx_reg, rx_reg;
    logic             done_reg, err_reg, go_reg;
    logic             timed_out;

    assign timed_out = (cnt_reg == TMO_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HS_IDLE:      if (start) state_next = HS_GO;
            HS_GO:        if (cnt_reg == GO_LAST) state_next = HS_WAIT_BUSY;
            HS_WAIT_BUSY: if (!idle_sync_reg || timed_out) state_next = idle_sync_reg ? HS_IDLE : HS_WAIT_IDLE;
            HS_WAIT_IDLE: if (idle_sync_reg || timed_out) state_next = HS_IDLE;
            default:      state_next = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HS_IDLE;
            cnt_reg       <= '0;
            idle_meta_reg <= 1'b1;
            idle_sync_reg <= 1'b1;
            tx_reg        <= SD_DUMMY;
            rx_reg        <= SD_DUMMY;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            go_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idle_meta_reg <= byte_idle;
            idle_sync_reg <= idle_meta_reg;
            // One counter serves both the GO width and the watchdog; it restarts on every state change.
            if (state_next != state_reg || state_reg == HS_IDLE) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == HS_IDLE && start) begin
                tx_reg <= tx;
            end
            if (state_reg == HS_WAIT_IDLE && idle_sync_reg) begin
                rx_reg <= byte_rx;
            end
            done_reg <= (state_reg == HS_WAIT_IDLE) && idle_sync_reg;
            err_reg  <= timed_out && (((state_reg == HS_WAIT_BUSY) && idle_sync_reg) ||
                                      ((state_reg == HS_WAIT_IDLE) && !idle_sync_reg));
            go_reg   <= (state_next == HS_GO);
        end
    end

    assign rx      = rx_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign byte_go = go_reg;
    assign byte_tx = tx_reg;

endmodule

// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command sequencer: power-up dummy clocks, 6-byte command framing, R1 polling
// and chip-select control. Define SD_CRC7_EN to compute CRC7 in hardware instead of using cmd_crc_i7.
module sd_cmd_seq
    import sd_cmd_seq_pkg::*;
#(
    parameter int GO_W       = 4,
    parameter int NCR_MAX    = 8,
    parameter int INIT_BYTES = 10,
    parameter int BUSY_TMO   = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        init_req_i,
    input  logic        cmd_req_i,
    input  logic [5:0]  cmd_idx_i6,
    input  logic [31:0] cmd_arg_i32,
    input  logic [6:0]  cmd_crc_i7,
    input  logic        cs_hold_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  r1_o8,
    output logic        timeout_o,
    output logic        cs_n_o,
    output logic        byte_go_o,
    output logic [7:0]  byte_tx_o8,
    input  logic [7:0]  byte_rx_i8,
    input  logic        byte_idle_i
);

    localparam int POLL_W = $clog2(NCR_MAX + 1);
    localparam logic [3:0]        INIT_LAST  = 4'(INIT_BYTES - 1);
    localparam logic [3:0]        FRAME_LAST = 4'd5;
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(NCR_MAX - 1);

    seq_state_t        state_reg, state_next;
    logic [3:0]        byte_cnt_reg;
    logic [POLL_W-1:0] poll_cnt_reg;
    logic [5:0]        idx_reg;
    logic [31:0]       arg_reg;
    logic              issued_reg, busy_reg, done_reg, timeout_reg, cs_n_reg;
    logic [7:0]        r1_reg;
    logic              accept, hs_start, hs_done, hs_err;
    logic [7:0]        hs_rx, tx_byte;
    logic [6:0]        crc_val;

    assign accept = (state_reg == ST_IDLE) && (init_req_i || cmd_req_i);

    always_comb begin
        state_next = state_reg;
        hs_start   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (init_req_i) state_next = ST_INIT;
                else if (cmd_req_i) state_next = ST_PRE;
            end
            ST_INIT, ST_PRE, ST_CMD, ST_POLL, ST_POST: begin
                // One start per byte; issued_reg is cleared when the handshake reports back.
                hs_start = !issued_reg;
                if (hs_err) begin
                    state_next = ST_FIN;
                end else if (hs_done) begin
                    case (state_reg)
                        ST_INIT: if (byte_cnt_reg == INIT_LAST) state_next = ST_FIN;
                        ST_PRE:  state_next = ST_CMD;
                        ST_CMD:  if (byte_cnt_reg == FRAME_LAST) state_next = ST_POLL;
                        ST_POLL: if (!hs_rx[7] || poll_cnt_reg == POLL_LAST) state_next = ST_POST;
                        default: state_next = ST_FIN;
                    endcase
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_byte = SD_DUMMY;
        if (state_reg == ST_CMD) begin
            case (byte_cnt_reg)
                4'd0:    tx_byte = {SD_START, idx_reg};
                4'd1:    tx_byte = arg_reg[31:24];
                4'd2:    tx_byte = arg_reg[23:16];
                4'd3:    tx_byte = arg_reg[15:8];
                4'd4:    tx_byte = arg_reg[7:0];
                default: tx_byte = {crc_val, 1'b1};
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= '0;
            poll_cnt_reg <= '0;
            idx_reg      <= '0;
            arg_reg      <= '0;
            issued_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            cs_n_reg     <= 1'b1;
            r1_reg       <= SD_DUMMY;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_next == ST_FIN);
            if (accept) begin
                busy_reg    <= 1'b1;
                timeout_reg <= 1'b0;
                idx_reg     <= cmd_idx_i6;
                arg_reg     <= cmd_arg_i32;
                cs_n_reg    <= init_req_i;
            end else if (state_reg == ST_FIN) begin
                busy_reg <= 1'b0;
            end
            if (hs_start) begin
                issued_reg <= 1'b1;
            end else if (hs_done || hs_err) begin
                issued_reg <= 1'b0;
            end
            if (state_next != state_reg) begin
                byte_cnt_reg <= '0;
            end else if (hs_done) begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
            if (accept) begin
                poll_cnt_reg <= '0;
            end else if (hs_done && state_reg == ST_POLL) begin
                poll_cnt_reg <= poll_cnt_reg + 1'b1;
                if (!hs_rx[7]) begin
                    r1_reg <= hs_rx;
                end else if (poll_cnt_reg == POLL_LAST) begin
                    r1_reg      <= SD_DUMMY;
                    timeout_reg <= 1'b1;
                end
            end
            if (hs_done && state_reg == ST_POST) begin
                cs_n_reg <= !cs_hold_i;
            end
            if (hs_err) begin
                r1_reg      <= SD_DUMMY;
                timeout_reg <= 1'b1;
                cs_n_reg    <= 1'b1;
            end
        end
    end

`ifdef SD_CRC7_EN
    logic [6:0] crc_reg;
    logic       crc_in_unused;

    assign crc_in_unused = ^cmd_crc_i7;

    // Accumulate over the 5 header bytes as each one is handed to the engine.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= '0;
        end else if (accept) begin
            crc_reg <= '0;
        end else if (hs_start && state_reg == ST_CMD && byte_cnt_reg != FRAME_LAST) begin
            crc_reg <= crc7_byte(crc_reg, tx_byte);
        end
    end
    assign crc_val = crc_reg;
`else
    logic [6:0] crc_in_reg;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            crc_in_reg <= '0;
        end else if (accept) begin
            crc_in_reg <= cmd_crc_i7;
        end
    end
    assign crc_val = crc_in_reg;
`endif

    sd_cmd_seq_byte_hs #(
        .GO_W     (GO_W),
        .BUSY_TMO (BUSY_TMO)
    ) u_byte_hs (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .start     (hs_start),
        .tx        (tx_byte),
        .rx        (hs_rx),
        .done      (hs_done),
        .err       (hs_err),
        .byte_go   (byte_go_o),
        .byte_tx   (byte_tx_o8),
        .byte_rx   (byte_rx_i8),
        .byte_idle (byte_idle_i)
    );

    assign busy_o    = busy_reg;
    assign done_o    = done_reg;
    assign r1_o8     = r1_reg;
    assign timeout_o = timeout_reg;
    assign cs_n_o    = cs_n_reg;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Bench for sd_cmd_seq: behavioural SPI engine with programmable rx stream and a
// transaction-level model of the expected byte stream, R1, timeout and chip-select.
module tb_sd_cmd_seq;

    localparam int GO_W       = 4;
    localparam int NCR_MAX    = 8;
    localparam int INIT_BYTES = 10;
    localparam int BUSY_TMO   = 1024;
    localparam int LIMIT      = 4000;

    logic        clk_i, rst_n;
    logic        init_req_i, cmd_req_i, cs_hold_i;
    logic [5:0]  cmd_idx_i6;
    logic [31:0] cmd_arg_i32;
    logic [6:0]  cmd_crc_i7;
    logic        busy_o, done_o, timeout_o, cs_n_o, byte_go_o;
    logic [7:0]  r1_o8, byte_tx_o8, byte_rx_i8;
    logic        byte_idle_i;

    logic [7:0] tx_seen[$];
    logic       cs_seen[$];
    int         go_seen[$];
    logic [7:0] rx_q[$];
    logic       stuck;
    int         done_cnt, seq_err, tx_unstable;
    logic       prev_done;
    int         n_checks, n_pass;
    logic [7:0] exp_r1_last;

    sd_cmd_seq dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .init_req_i  (init_req_i),
        .cmd_req_i   (cmd_req_i),
        .cmd_idx_i6  (cmd_idx_i6),
        .cmd_arg_i32 (cmd_arg_i32),
        .cmd_crc_i7  (cmd_crc_i7),
        .cs_hold_i   (cs_hold_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .r1_o8       (r1_o8),
        .timeout_o   (timeout_o),
        .cs_n_o      (cs_n_o),
        .byte_go_o   (byte_go_o),
        .byte_tx_o8  (byte_tx_o8),
        .byte_rx_i8  (byte_rx_i8),
        .byte_idle_i (byte_idle_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // CRC7 as polynomial long division of the 40-bit header by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    // Behavioural shift engine: starts on GO fall, goes busy, returns the next rx byte on idle.
    initial begin : engine
        int         go_len;
        logic [7:0] cap;
        go_len      = 0;
        byte_idle_i = 1'b1;
        byte_rx_i8  = 8'hFF;
        forever begin
            @(posedge clk_i); #1;
            if (byte_go_o) begin
                go_len++;
            end else if (go_len != 0) begin
                cap = byte_tx_o8;
                tx_seen.push_back(cap);
                cs_seen.push_back(cs_n_o);
                go_seen.push_back(go_len);
                go_len = 0;
                if (!stuck) begin
                    repeat ($urandom_range(1, 3)) begin @(posedge clk_i); #1; end
                    byte_idle_i = 1'b0;
                    repeat ($urandom_range(2, 10)) begin
                        @(posedge clk_i); #1;
                        if (byte_tx_o8 !== cap) tx_unstable++;
                    end
                    byte_rx_i8  = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hFF;
                    byte_idle_i = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
        if (done_o && !busy_o) seq_err++;
        if (prev_done && busy_o) seq_err++;
        prev_done = done_o;
    end

    task automatic issue(input logic do_init, input logic do_cmd);
        @(posedge clk_i); #1;
        init_req_i = do_init;
        cmd_req_i  = do_cmd;
        @(posedge clk_i); #1;
        init_req_i = 1'b0;
        cmd_req_i  = 1'b0;
    endtask

    task automatic wait_done(input int d0, output int cyc);
        cyc = 0;
        while (done_cnt == d0 && cyc < LIMIT) begin
            @(negedge clk_i);
            cyc++;
        end
        repeat (30) @(negedge clk_i);
    endtask

    task automatic clear_logs();
        tx_seen.delete();
        cs_seen.delete();
        go_seen.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, timeout_o, cs_n_o, byte_go_o} !== 5'b00010) begin
            $display("FAIL reset_ctrl: busy/done/tmo/cs_n/go = %b, want 00010",
                     {busy_o, done_o, timeout_o, cs_n_o, byte_go_o});
        end else n_pass++;
        n_checks++;
        if ({r1_o8, byte_tx_o8} !== 16'hFFFF) begin
            $display("FAIL reset_data: r1=%h tx=%h, want FF FF", r1_o8, byte_tx_o8);
        end else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk_i);
        $display("reset: outputs idle");
    endtask

    task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc_in, input logic hold, input int resp_poll,
                           input logic [7:0] resp, input logic extra);
        logic [7:0]  exp_tx[$];
        logic [39:0] hdr;
        logic [6:0]  crc_exp;
        logic [7:0]  exp_r1;
        logic        exp_tmo;
        int          npoll, d0, cyc, bad, n_cs, n_go;
        hdr = {2'b01, idx, arg};
`ifdef SD_CRC7_EN
        crc_exp = crc7_ref(hdr);
`else
        crc_exp = crc_in;
`endif
        rx_q.delete();
        for (int i = 0; i < 7; i++) rx_q.push_back(8'($urandom));
        for (int p = 1; p <= NCR_MAX + 1; p++) begin
            rx_q.push_back((p == resp_poll) ? resp : (8'($urandom) | 8'h80));
        end
        if (resp_poll >= 1 && resp_poll <= NCR_MAX) begin
            npoll = resp_poll; exp_r1 = resp; exp_tmo = 1'b0;
        end else begin
            npoll = NCR_MAX; exp_r1 = 8'hFF; exp_tmo = 1'b1;
        end
        exp_tx.push_back(8'hFF);
        for (int b = 4; b >= 0; b--) exp_tx.push_back(hdr[b*8 +: 8]);
        exp_tx.push_back({crc_exp, 1'b1});
        for (int p = 0; p <= npoll; p++) exp_tx.push_back(8'hFF);

        clear_logs();
        d0          = done_cnt;
        cmd_idx_i6  = idx;
        cmd_arg_i32 = arg;
        cmd_crc_i7  = crc_in;
        cs_hold_i   = hold;
        issue(1'b0, 1'b1);
        if (extra) begin
            repeat (25) @(posedge clk_i);
            #1;
            cmd_idx_i6 = ~idx;
            cmd_req_i  = 1'b1;
            @(posedge clk_i); #1;
            cmd_req_i  = 1'b0;
        end
        wait_done(d0, cyc);

        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL %s done_pulses: got %0d, want 1", name, done_cnt - d0);
        else n_pass++;
        bad = -1;
        if (tx_seen.size() != exp_tx.size()) bad = 999;
        else foreach (exp_tx[i]) if (bad < 0 && tx_seen[i] !== exp_tx[i]) bad = i;
        n_checks++;
        if (bad == 999) $display("FAIL %s tx_count: got %0d bytes, want %0d", name, tx_seen.size(), exp_tx.size());
        else if (bad >= 0) $display("FAIL %s tx_byte[%0d]: got %h, want %h", name, bad, tx_seen[bad], exp_tx[bad]);
        else n_pass++;
        n_cs = 0;
        n_go = 0;
        foreach (cs_seen[i]) if (cs_seen[i] !== 1'b0) n_cs++;
        foreach (go_seen[i]) if (go_seen[i] != GO_W) n_go++;
        n_checks++;
        if (n_cs != 0) $display("FAIL %s cs_during_bytes: %0d bytes with cs_n high, want 0", name, n_cs);
        else n_pass++;
        n_checks++;
        if (n_go != 0) $display("FAIL %s go_width: %0d bytes with go width != %0d", name, n_go, GO_W);
        else n_pass++;
        n_checks++;
        if (r1_o8 !== exp_r1) $display("FAIL %s r1: got %h, want %h", name, r1_o8, exp_r1);
        else n_pass++;
        n_checks++;
        if (timeout_o !== exp_tmo) $display("FAIL %s timeout: got %b, want %b", name, timeout_o, exp_tmo);
        else n_pass++;
        n_checks++;
        if ({busy_o, cs_n_o} !== {1'b0, ~hold}) $display("FAIL %s busy/cs_n after: got %b, want %b", name, {busy_o, cs_n_o}, {1'b0, ~hold});
        else n_pass++;
        exp_r1_last = exp_r1;
        $display("%s: idx=%0d arg=%h hold=%0b polls=%0d -> r1=%h tmo=%0b bytes=%0d",
                 name, idx, arg, hold, npoll, r1_o8, timeout_o, tx_seen.size());
    endtask

    task automatic test_cmd0();
        run_cmd("cmd0", 6'd0, 32'h0, 7'h4A, 1'b0, 2, 8'h01, 1'b0);
        n_checks++;
        if (tx_seen.size() < 7 || tx_seen[6] !== 8'h95) $display("FAIL cmd0 crc_byte: got %h, want 95", (tx_seen.size() >= 7) ? tx_seen[6] : 8'hxx);
        else n_pass++;
    endtask

    task automatic test_cmd8_hold();
        run_cmd("cmd8_hold", 6'd8, 32'h0000_01AA, crc7_ref({2'b01, 6'd8, 32'h0000_01AA}), 1'b1, 1, 8'h01, 1'b0);
        n_checks++;
        if (tx_seen.size() < 7 || tx_seen[6] !== 8'h87) $display("FAIL cmd8 crc_byte: got %h, want 87", (tx_seen.size() >= 7) ? tx_seen[6] : 8'hxx);
        else n_pass++;
    endtask

    task automatic test_init_priority();
        int d0, cyc, bad;
        clear_logs();
        d0 = done_cnt;
        cmd_idx_i6 = 6'd17;
        issue(1'b1, 1'b1);
        wait_done(d0, cyc);
        bad = 0;
        foreach (tx_seen[i]) if (tx_seen[i] !== 8'hFF || cs_seen[i] !== 1'b1) bad++;
        n_checks++;
        if (tx_seen.size() != INIT_BYTES || bad != 0) $display("FAIL init_bytes: got %0d bytes (%0d not FF with cs_n high), want %0d", tx_seen.size(), bad, INIT_BYTES);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL init_done_pulses: got %0d, want 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if ({r1_o8, timeout_o, cs_n_o, busy_o} !== {exp_r1_last, 3'b010}) $display("FAIL init_state: r1/tmo/cs_n/busy = %h %b, want %h 010", r1_o8, {timeout_o, cs_n_o, busy_o}, exp_r1_last);
        else n_pass++;
        $display("init: bytes=%0d cs_n=%0b r1=%h", tx_seen.size(), cs_n_o, r1_o8);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_cmd("rand", 6'($urandom), $urandom, 7'($urandom), 1'($urandom),
                    $urandom_range(0, NCR_MAX + 1), 8'($urandom) & 8'h7F, 1'b0);
        end
    endtask

    task automatic test_stuck_idle();
        int d0, cyc;
        stuck = 1'b1;
        clear_logs();
        d0 = done_cnt;
        cs_hold_i = 1'b1;
        issue(1'b0, 1'b1);
        wait_done(d0, cyc);
        stuck = 1'b0;
        n_checks++;
        if (cyc < BUSY_TMO || cyc > BUSY_TMO + 60) $display("FAIL stuck_abort_time: got %0d cycles, want %0d..%0d", cyc, BUSY_TMO, BUSY_TMO + 60);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1 || tx_seen.size() != 1) $display("FAIL stuck_done: pulses=%0d bytes=%0d, want 1 1", done_cnt - d0, tx_seen.size());
        else n_pass++;
        n_checks++;
        if ({r1_o8, timeout_o, cs_n_o} !== {8'hFF, 2'b11}) $display("FAIL stuck_state: r1/tmo/cs_n = %h %b, want FF 11", r1_o8, {timeout_o, cs_n_o});
        else n_pass++;
        $display("stuck: abort after %0d cycles r1=%h tmo=%0b", cyc, r1_o8, timeout_o);
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_logs();
        rx_q.delete();
        cmd_idx_i6  = 6'd9;
        cmd_arg_i32 = 32'hDEAD_BEEF;
        cs_hold_i   = 1'b0;
        issue(1'b0, 1'b1);
        cyc = 0;
        while (!(tx_seen.size() >= 4 && byte_go_o) && cyc < LIMIT) begin
            @(negedge clk_i);
            cyc++;
        end
        n_checks++;
        if (cyc >= LIMIT) $display("FAIL reset_mid_reach: byte 3 go not seen, got %0d bytes, want 4", tx_seen.size());
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, timeout_o, cs_n_o, byte_go_o, r1_o8, byte_tx_o8} !== {5'b00010, 16'hFFFF}) begin
            $display("FAIL reset_mid: busy/done/tmo/cs_n/go=%b r1=%h tx=%h, want 00010 FF FF",
                     {busy_o, done_o, timeout_o, cs_n_o, byte_go_o}, r1_o8, byte_tx_o8);
        end else n_pass++;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (60) @(negedge clk_i);
        clear_logs();
        $display("reset_mid: outputs returned to reset values");
    endtask

    initial begin
        rst_n = 1'b0; init_req_i = 1'b0; cmd_req_i = 1'b0; cs_hold_i = 1'b0;
        cmd_idx_i6 = '0; cmd_arg_i32 = '0; cmd_crc_i7 = '0;
        stuck = 1'b0; done_cnt = 0; seq_err = 0; tx_unstable = 0; prev_done = 1'b0;
        n_checks = 0; n_pass = 0; exp_r1_last = 8'hFF;

        test_reset();
        test_cmd0();
        run_cmd("cmd55_tmo", 6'd55, 32'h0, crc7_ref({2'b01, 6'd55, 32'h0}), 1'b1, 0, 8'h00, 1'b0);
        test_cmd8_hold();
        test_init_priority();
        run_cmd("busy_drop", 6'd0, 32'h0, 7'h4A, 1'b0, 1, 8'h01, 1'b1);
        run_cmd("last_poll", 6'd41, 32'h4000_0000, 7'h77, 1'b0, NCR_MAX, 8'h00, 1'b0);
        test_random();
        test_stuck_idle();
        test_reset_mid();
        run_cmd("recover", 6'd16, 32'h0000_0200, 7'h0A, 1'b0, 3, 8'h00, 1'b0);

        n_checks++;
        if (seq_err != 0) $display("FAIL done_busy_align: %0d cycles out of step, want 0", seq_err);
        else n_pass++;
        n_checks++;
        if (tx_unstable != 0) $display("FAIL tx_stable: %0d samples changed mid-byte, want 0", tx_unstable);
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
